// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit mini-MIPS datapath.
// Fetches a 32-bit instruction as four byte reads, then decodes and sequences execution.
module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       memtoreg,
  output logic       iord,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic [1:0] pcsource,
  output logic [1:0] aluop,
  output logic [3:0] irwrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Plain 4-bit register so the unused code 15 is representable and recovers to FETCH1.
  logic [3:0] state_r;
  logic [3:0] state_n;
  logic       pcwrite;
  logic       branch;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= FETCH1;
    else        state_r <= state_n;
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_n = FETCH1;
    case (state_r)
      FETCH1: state_n = FETCH2;
      FETCH2: state_n = FETCH3;
      FETCH3: state_n = FETCH4;
      FETCH4: state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: state_n = MEMADR;
          OP_RTYPE:     state_n = RTYPEEX;
          OP_BEQ:       state_n = BEQEX;
          OP_J:         state_n = JEX;
          OP_ADDI:      state_n = ADDIEX;
          default:      state_n = FETCH1;
        endcase
      end
      MEMADR: begin
        if (op == OP_LB)      state_n = LBRD;
        else if (op == OP_SB) state_n = SBWR;
        else                  state_n = FETCH1;
      end
      LBRD:    state_n = LBWR;
      RTYPEEX: state_n = RTYPEWR;
      ADDIEX:  state_n = ADDIWR;
      default: state_n = FETCH1;
    endcase
  end

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    memtoreg = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    pcsource = 2'b00;
    aluop    = 2'b00;
    irwrite  = 4'b0000;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_r)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread = 1'b1;
        irwrite = 4'b0001 << state_r[1:0];
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        branch   = 1'b1;
        pcsource = 2'b01;
      end
      JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      ADDIWR: regwrite = 1'b1;
      default: ;
    endcase
  end

  // Only the branch path lets an input reach an output combinationally.
  assign pcen  = pcwrite | (branch & zero);
  assign state = state_r;

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control FSM for the 8-bit mini-MIPS datapath. It decodes the opcode and generates every datapath select and enable, including the 2-bit ALU source-B select that steers the four-input source-B mux. One 32-bit instruction is fetched as four byte reads, then decoded and executed over 1–3 further states. Outputs are Moore, decoded from state, except `pcen`, which also depends on `zero`.

## Interface
- No parameters; opcode width fixed at 6.
- `clk` input 1 — system clock, rising edge.
- `reset` input 1 — asynchronous, active-low; 0 forces FETCH1 immediately.
- `op` input 6 — instruction[31:26] from the instruction register.
- `zero` input 1 — ALU zero flag.
- `memread` output 1 — memory read strobe.
- `memwrite` output 1 — memory write strobe.
- `alusrca` output 1 — ALU A: 0 = PC, 1 = register A.
- `alusrcb` output 2 — ALU B: 00 = reg B, 01 = constant 1, 10 = immediate, 11 = branch offset.
- `memtoreg` output 1 — write-back source: 1 = memory data.
- `iord` output 1 — address source: 0 = PC, 1 = ALUOut.
- `pcen` output 1 — PC load enable.
- `regwrite` output 1 — register file write.
- `regdst` output 1 — destination: 1 = rd, 0 = rt.
- `pcsource` output 2 — 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` output 2 — 00 = add, 01 = subtract, 10 = use funct.
- `irwrite` output 4 — one-hot byte enable into the instruction register.
- `state` output 4 — current state encoding (debug/verification).

## Operation
- State encoding: FETCH1 = 0, FETCH2 = 1, FETCH3 = 2, FETCH4 = 3, DECODE = 4, MEMADR = 5, LBRD = 6, LBWR = 7, SBWR = 8, RTYPEEX = 9, RTYPEWR = 10, BEQEX = 11, JEX = 12, ADDIEX = 13, ADDIWR = 14. Code 15 is illegal and goes to FETCH1.
- Opcodes: LB = 100000, SB = 101000, RTYPE = 000000, BEQ = 000100, J = 000010, ADDI = 001000.
- Transitions:
  - FETCH1 → FETCH2 → FETCH3 → FETCH4 → DECODE.
  - DECODE: LB or SB → MEMADR; RTYPE → RTYPEEX; BEQ → BEQEX; J → JEX; ADDI → ADDIEX; any other opcode → FETCH1.
  - MEMADR: LB → LBRD → LBWR → FETCH1; SB → SBWR → FETCH1.
  - RTYPEEX → RTYPEWR → FETCH1.
  - ADDIEX → ADDIWR → FETCH1.
  - BEQEX → FETCH1; JEX → FETCH1.
- Outputs per state (anything not listed is 0):
  - FETCHn: `memread` = 1, `irwrite` = 1<<(n-1), `alusrcb` = 01, pcwrite = 1.
  - DECODE: `alusrcb` = 11.
  - MEMADR and ADDIEX: `alusrca` = 1, `alusrcb` = 10.
  - LBRD: `memread` = 1, `iord` = 1.
  - LBWR: `regwrite` = 1, `memtoreg` = 1.
  - SBWR: `memwrite` = 1, `iord` = 1.
  - RTYPEEX: `alusrca` = 1, `aluop` = 10.
  - RTYPEWR: `regwrite` = 1, `regdst` = 1.
  - BEQEX: `alusrca` = 1, `aluop` = 01, branch = 1, `pcsource` = 01.
  - JEX: pcwrite = 1, `pcsource` = 10.
  - ADDIWR: `regwrite` = 1.
- `pcen` = pcwrite | (branch & `zero`). This is the only output that depends on an input.
- `op` is sampled only in DECODE and MEMADR. It must remain stable after FETCH4 because `irwrite` is 0 from then on.

## Timing
- Reset (`reset` = 0): `state` = 0 asynchronously, so outputs show FETCH1 values:
  - `memread` = 1, `irwrite` = 0001, `alusrcb` = 01, `pcen` = 1.
  - All other outputs 0.
  - This holds for as long as reset is held. The bench treats memory/PC effects during reset as don't-care.
- Reset release: first rising edge after `reset` returns to 1 moves FETCH1 → FETCH2.
- Reset asserted mid-instruction: abandon immediately and return to FETCH1. No partial write-back strobe may persist past the reset assertion.
- Per-instruction cycles, FETCH1 to the next FETCH1:
  - LB 8; SB 7; RTYPE 7; ADDI 7; BEQ 6; J 6.
  - Illegal opcode 5.
- `pcen` is combinational within the BEQEX cycle: the PC loads at the end of BEQEX only if `zero` = 1.
- Exactly one `irwrite` bit is high during each fetch cycle; `irwrite` = 0000 in every other state.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles mid-RTYPEEX, then release → `state` = 0 immediately, FETCH1 outputs as listed, `state` = 1 after the first edge.
- Fetch: `irwrite` sequence 0001, 0010, 0100, 1000 and `pcen` = 1 in each of the 4 fetch cycles; `alusrcb` = 01 throughout; then DECODE with `alusrcb` = 11.
- LB (`op` = 100000) → states 0,1,2,3,4,5,6,7,0. `iord` = 1 in LBRD; `regwrite` = `memtoreg` = 1 in LBWR. SB (`op` = 101000) → 0..4,5,8,0 with `memwrite` = 1 only in SBWR.
- BEQ (`op` = 000100) → `pcen` = 1 in BEQEX when `zero` = 1 and 0 when `zero` = 0; `aluop` = 01, `pcsource` = 01; 6 cycles.
- RTYPE, ADDI, J:
  - RTYPE → `aluop` = 10, then `regdst` = `regwrite` = 1.
  - ADDI → `alusrcb` = 10, then `regwrite` = 1 with `regdst` = 0.
  - J → `pcsource` = 10 with `pcen` = 1.
- Illegal opcode 111111 in DECODE → next state FETCH1, no `regwrite`, `memwrite`, or `pcen` strobe; force `state` = 15 → FETCH1 next cycle.
